core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
Consumes the single-cycle button event pulses produced by the button parser chain (sync -> debounce -> edge detect, WIDTH=4) and turns them into run/halt/single-step/soft-reset control for the RISC-V core on the FPGA.
Owns a 4-state FSM, a cycle timer for step and reset windows, and a step counter exposed for LED/debug display.
Sits between the button parser and the core clock-enable/soft-reset inputs.

Parameters:
RST_PULSE_CYCLES, 16, cycles core_soft_rst is held high per reset request; legal range >= 1.
STEP_CYCLES, 1, core_clk_en cycles granted per single-step request; legal range >= 1.
STEP_CNT_WIDTH, 16, width of the step counter.
RUN_ON_RESET, 0, 1 = leave reset in RUN, 0 = leave reset in HALT.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
btn_pulse  input  4  one-cycle event pulses: [0] run/halt toggle, [1] single step, [2] soft reset, [3] clear step counter.
core_clk_en  output  1  core advance enable, registered.
core_soft_rst  output  1  core soft reset, active high, registered.
halted  output  1  high when the FSM is in HALT, registered.
step_count  output  STEP_CNT_WIDTH  number of single steps taken since the last clear, registered.
state  output  2  FSM state encoding, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = RUN if RUN_ON_RESET else HALT.
  - core_clk_en = RUN_ON_RESET.
  - core_soft_rst = 0.
  - halted = !RUN_ON_RESET.
  - step_count = 0, timer = 0.
- States and encoding: HALT=0, RUN=1, STEP=2, SRST=3.
- Latency: all outputs are registered. A pulse sampled in cycle N changes the outputs in cycle N+1.
- Priority within one cycle: btn_pulse[2] > btn_pulse[0] > btn_pulse[1]. btn_pulse[3] is independent of the others (see counter rules).
- HALT:
  - core_clk_en = 0.
  - [2] -> SRST.
  - [0] -> RUN.
  - [1] -> STEP; load timer = STEP_CYCLES-1; step_count += 1.
- RUN:
  - core_clk_en = 1.
  - [2] -> SRST.
  - [0] -> HALT.
  - [1] is ignored.
- STEP:
  - core_clk_en = 1 for exactly STEP_CYCLES cycles, then -> HALT with core_clk_en = 0.
  - [0] and [1] are dropped, not queued.
  - [2] aborts the step -> SRST; core_clk_en drops in the next cycle.
- SRST:
  - core_soft_rst = 1 and core_clk_en = 0 for exactly RST_PULSE_CYCLES cycles, then -> HALT.
  - step_count is cleared on entry.
  - A further [2] while in SRST reloads the timer, extending the window to RST_PULSE_CYCLES cycles from that pulse.
  - [0] and [1] are dropped.
- Counter rules:
  - step_count wraps modulo 2^STEP_CNT_WIDTH (all ones + 1 -> 0, no saturation).
  - [3] clears step_count in any state.
  - If [3] coincides with a step entry, the clear wins: count = 0, the step still executes.
- Timer: down-counter sized $clog2(max(RST_PULSE_CYCLES, STEP_CYCLES)+1). Exit the window when the timer reads 0 and the state is STEP or SRST.
- No illegal states are reachable with 2-bit encoding. A default branch returns to HALT.
- Multiple simultaneous pulses are resolved by the priority rule. No pulse is ever remembered across cycles.

Decomposition:
- Shared defines/include (core_run_ctrl_defs): state encodings HALT/RUN/STEP/SRST and the button index constants BTN_RUN=0, BTN_STEP=1, BTN_SRST=2, BTN_CLR=3, so the top-level and the bench agree with the button parser WIDTH=4 mapping.
- One sub-module: window_timer. Loadable down-counter with a load value, load strobe, and a done flag. It is instantiated once and shared by the STEP and SRST windows.
- The FSM and step counter stay in core_run_ctrl.

Test Plan:
- Reset with RUN_ON_RESET=0, then release: halted=1, core_clk_en=0, step_count=0. Pulse [0] at cycle 10 -> core_clk_en=1 from cycle 11. Pulse [0] at cycle 20 -> core_clk_en=0 from cycle 21.
- From HALT with STEP_CYCLES=3, pulse [1] -> core_clk_en high for exactly 3 cycles, then halted=1, step_count=1. Repeat 5 times -> step_count=5.
- From RUN, pulse [2] with RST_PULSE_CYCLES=16 -> core_soft_rst high for 16 cycles, step_count=0, then HALT. A second [2] at reset cycle 10 -> 26 total high cycles.
- Simultaneous [0]+[1]+[2] in HALT -> SRST only. [1]+[3] in HALT -> one step executes, step_count=0. [1] during STEP or RUN -> no effect.
- STEP_CNT_WIDTH=4: 16 steps -> step_count wraps 15 -> 0.
- Assert rst_n low mid-STEP and mid-SRST, asynchronously between clock edges -> outputs return to reset values immediately. Subsequent [0] behaves normally.

Source files
------------

// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the core run controller: FSM state encoding,
// button-pulse bit positions (button parser WIDTH=4 mapping) and a sizing helper.
package core_run_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    SRST = 2'd3
  } run_state_e;

  localparam int BTN_WIDTH = 4;
  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_SRST  = 2;
  localparam int BTN_CLR   = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_run_ctrl_window_timer.sv
// Loadable down-counter shared by the single-step and soft-reset windows;
// done is high whenever the count has reached zero.
module window_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step/soft-reset controller for the RISC-V core, driven by
// one-cycle button event pulses. All outputs are registered.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int STEP_CYCLES      = 1,
  parameter int STEP_CNT_WIDTH   = 16,
  parameter bit RUN_ON_RESET     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BTN_WIDTH-1:0]      btn_pulse,
  output logic                      core_clk_en,
  output logic                      core_soft_rst,
  output logic                      halted,
  output logic [STEP_CNT_WIDTH-1:0] step_count,
  output logic [1:0]                state
);

  localparam int TIMER_W = $clog2(max_int(RST_PULSE_CYCLES, STEP_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] RST_LOAD  = TIMER_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STEP_LOAD = TIMER_W'(STEP_CYCLES - 1);
  localparam run_state_e RESET_STATE = RUN_ON_RESET ? RUN : HALT;

  run_state_e       state_q;
  run_state_e       state_nxt;
  logic             timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic             timer_done;
  logic             step_inc;
  logic             cnt_clr;

  logic req_run, req_step, req_srst;
  assign req_run  = btn_pulse[BTN_RUN];
  assign req_step = btn_pulse[BTN_STEP];
  assign req_srst = btn_pulse[BTN_SRST];

  // Soft reset outranks run/halt, which outranks single step. Pulses that a
  // state does not act on are simply dropped.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt  = state_q;
    timer_load = 1'b0;
    timer_val  = RST_LOAD;
    step_inc   = 1'b0;
    unique case (state_q)
      HALT: begin
        if (req_srst) begin
          state_nxt  = SRST;
          timer_load = 1'b1;
        end else if (req_run) begin
          state_nxt = RUN;
        end else if (req_step) begin
          state_nxt  = STEP;
          timer_load = 1'b1;
          timer_val  = STEP_LOAD;
          step_inc   = 1'b1;
        end
      end
      RUN: begin
        if (req_srst) begin
          state_nxt  = SRST;
          timer_load = 1'b1;
        end else if (req_run) begin
          state_nxt = HALT;
        end
      end
      STEP: begin
        if (req_srst) begin
          state_nxt  = SRST;
          timer_load = 1'b1;
        end else if (timer_done) begin
          state_nxt = HALT;
        end
      end
      SRST: begin
        // A repeated request restarts the full reset window from this pulse.
        if (req_srst) begin
          timer_load = 1'b1;
        end else if (timer_done) begin
          state_nxt = HALT;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // Clear wins over a coincident step increment; the step itself still runs.
  assign cnt_clr = btn_pulse[BTN_CLR] || (state_nxt == SRST);

  window_timer #(
    .WIDTH(TIMER_W)
  ) u_window_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      core_clk_en   <= RUN_ON_RESET;
      core_soft_rst <= 1'b0;
      halted        <= !RUN_ON_RESET;
      step_count    <= '0;
    end else begin
      state_q       <= state_nxt;
      core_clk_en   <= (state_nxt == RUN) || (state_nxt == STEP);
      core_soft_rst <= (state_nxt == SRST);
      halted        <= (state_nxt == HALT);
      if (cnt_clr) begin
        step_count <= '0;
      end else if (step_inc) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: the driver queues the hand-derived
// expected state/count per cycle, a monitor pops and compares after each edge.
module tb_core_run_ctrl;
  import core_run_ctrl_pkg::*;

  localparam int RSTC  = 16;
  localparam int STEPC = 3;
  localparam int CW    = 4;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_RUN  = 4'(1 << BTN_RUN);
  localparam logic [3:0] B_STEP = 4'(1 << BTN_STEP);
  localparam logic [3:0] B_SRST = 4'(1 << BTN_SRST);
  localparam logic [3:0] B_CLR  = 4'(1 << BTN_CLR);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    btn_pulse = '0;
  logic          core_clk_en;
  logic          core_soft_rst;
  logic          halted;
  logic [CW-1:0] step_count;
  logic [1:0]    state;

  core_run_ctrl #(
    .RST_PULSE_CYCLES (RSTC),
    .STEP_CYCLES      (STEPC),
    .STEP_CNT_WIDTH   (CW),
    .RUN_ON_RESET     (1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_pulse     (btn_pulse),
    .core_clk_en   (core_clk_en),
    .core_soft_rst (core_soft_rst),
    .halted        (halted),
    .step_count    (step_count),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  int   cyc_no   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per clock while enabled.
  always @(posedge clk) begin
    exp_t e;
    if (mon_en) begin
      #1;
      cyc_no++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow cycle=%0d actual=empty expected=entry", cyc_no);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("c%0d state", cyc_no), 32'(state), 32'(e.st));
        check($sformatf("c%0d clk_en", cyc_no), 32'(core_clk_en),
              32'((e.st == RUN) || (e.st == STEP)));
        check($sformatf("c%0d soft_rst", cyc_no), 32'(core_soft_rst), 32'(e.st == SRST));
        check($sformatf("c%0d halted", cyc_no), 32'(halted), 32'(e.st == HALT));
        check($sformatf("c%0d step_count", cyc_no), 32'(step_count), 32'(e.cnt));
      end
    end
  end

  // Drive one cycle of pulses (from a negedge) and queue the post-edge expectation.
  task automatic cyc(input logic [3:0] b, input run_state_e st, input int cnt);
    exp_t e;
    e.st  = st;
    e.cnt = cnt[CW-1:0];
    btn_pulse = b;
    sb_q.push_back(e);
    @(negedge clk);
    btn_pulse = B_NONE;
  endtask

  task automatic idle(input int n, input run_state_e st, input int cnt);
    repeat (n) cyc(B_NONE, st, cnt);
  endtask

  task automatic do_step(input int cnt);
    cyc(B_STEP, STEP, cnt);
    idle(STEPC - 1, STEP, cnt);
    idle(1, HALT, cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " clk_en"}, 32'(core_clk_en), 32'd0);
    check({tag, " soft_rst"}, 32'(core_soft_rst), 32'd0);
    check({tag, " halted"}, 32'(halted), 32'd1);
    check({tag, " step_count"}, 32'(step_count), 32'd0);
    check({tag, " state"}, 32'(state), 32'(HALT));
  endtask

  task automatic async_reset(input string tag);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12 check_reset_vals("por");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Run/halt toggling; a step request while running is ignored.
    idle(9, HALT, 0);
    cyc(B_RUN, RUN, 0);
    idle(8, RUN, 0);
    cyc(B_STEP, RUN, 0);
    cyc(B_RUN, HALT, 0);
    idle(2, HALT, 0);

    // Five single steps of STEPC cycles; the third also gets run+step mid-step.
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) begin
        cyc(B_STEP, STEP, i);
        cyc(B_STEP | B_RUN, STEP, i);
        idle(1, STEP, i);
        idle(1, HALT, i);
      end else begin
        do_step(i);
      end
    end

    // Clear coincident with a step: count is zero but the step runs.
    cyc(B_STEP | B_CLR, STEP, 0);
    idle(STEPC - 1, STEP, 0);
    idle(1, HALT, 0);

    // Sixteen steps wrap the 4-bit counter 15 -> 0.
    for (int i = 1; i <= 16; i++) do_step(i % 16);
    do_step(1);
    do_step(2);
    cyc(B_CLR, HALT, 0);
    do_step(1);

    // Soft reset from RUN: 16 cycles, count cleared on entry.
    cyc(B_RUN, RUN, 1);
    cyc(B_SRST, SRST, 0);
    idle(RSTC - 1, SRST, 0);
    idle(1, HALT, 0);

    // Second request at reset cycle 10 stretches the window to 26 cycles.
    do_step(1);
    cyc(B_RUN, RUN, 1);
    cyc(B_SRST, SRST, 0);
    idle(9, SRST, 0);
    cyc(B_SRST, SRST, 0);
    idle(RSTC - 1, SRST, 0);
    idle(1, HALT, 0);

    // All three of run/step/srst in HALT -> soft reset only; run/step dropped inside.
    do_step(1);
    cyc(B_RUN | B_STEP | B_SRST, SRST, 0);
    cyc(B_RUN | B_STEP, SRST, 0);
    idle(RSTC - 2, SRST, 0);
    idle(1, HALT, 0);

    // Soft reset aborts a step in progress.
    cyc(B_STEP, STEP, 1);
    cyc(B_SRST, SRST, 0);
    idle(RSTC - 1, SRST, 0);
    idle(1, HALT, 0);

    // Asynchronous reset mid-step, then normal run/halt.
    do_step(1);
    cyc(B_STEP, STEP, 2);
    async_reset("async_step");
    cyc(B_RUN, RUN, 0);
    cyc(B_RUN, HALT, 0);

    // Asynchronous reset mid-soft-reset, then normal run/halt.
    cyc(B_SRST, SRST, 0);
    idle(3, SRST, 0);
    async_reset("async_srst");
    cyc(B_RUN, RUN, 0);
    idle(2, RUN, 0);
    cyc(B_RUN, HALT, 0);
    idle(2, HALT, 0);

    mon_en = 1'b0;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
